nv_clk_gate_ctrl: RTL
=====================

// Module: nv_clk_gate_ctrl
// PURPOSE
//  Idle-detect controller that produces clk_en for the latch-based clock gate cell (NV_CLK_gate_power) guarding one
//  clock domain. Watches upstream requests and domain busy status, drops clk_en after a programmable idle
//  hysteresis, and re-enables it on demand. Holds act_ready low until the gated clock is running again.
//  Runs on the free-running (ungated) clock; sits in the parent next to the gate cell.
// PARAMETERS
//  CNT_W     8   width of idle hysteresis counter and cfg_idle_thresh
//  WAKE_CYC  2   cycles from clk_en rising to act_ready rising (>=1); covers gate latch and domain settle
//  EVT_W     16  width of saturating gate-event counter
// PORTS
//  clk              in   1      free-running core clock (never gated)
//  reset            in   1      synchronous, active-high reset
//  cfg_force_on     in   1      1 = never gate (SLCG disable); also forces wake from OFF
//  cfg_idle_thresh  in   CNT_W  idle hysteresis threshold, sampled live every cycle
//  act_valid        in   1      upstream request into the gated domain (valid/ready, held until accepted)
//  act_ready        out  1      1 = gated clock running, request may transfer
//  dom_busy         in   1      gated domain has in-flight work
//  clk_en           out  1      enable to the clock-gate cell, registered
//  gated            out  1      status: 1 while in OFF state
//  gate_events      out  EVT_W  count of entries into OFF, saturating at all-ones
// BEHAVIOUR
//  - Reset (sync, active-high): state=RUN, clk_en=1, gated=0, act_ready=1 after first reset edge, idle_cnt=0,
//    wake_cnt=0, gate_events=0. clk_en=1 in reset keeps the domain clocked so its own sync reset takes effect.
//  - idle = !act_valid && !dom_busy && !cfg_force_on (combinational, sampled each edge).
//  - States (2-bit): RUN=0, HYST=1, OFF=2, WAKE=3. clk_en/gated are registered. act_ready is a decode of the
//    registered state: 1 in RUN/HYST, 0 in OFF/WAKE. A transfer occurs on act_valid && act_ready.
//  - RUN: idle -> HYST, idle_cnt<=0. Else stay.
//  - HYST: !idle -> RUN (non-idle always wins, even when idle_cnt reaches threshold that cycle).
//    idle && idle_cnt>=cfg_idle_thresh -> OFF, clk_en<=0, gated<=1, gate_events++ (saturate).
//    else idle_cnt++. Using >= makes a mid-HYST threshold decrease gate on the next idle cycle.
//  - Gating latency: clk_en is 0 starting on the edge after thresh+2 consecutive idle cycles.
//  - OFF: any of act_valid, dom_busy, cfg_force_on -> WAKE, clk_en<=1, gated<=0, wake_cnt<=0.
//    dom_busy in OFF counts as a wake request (never trust a stale busy).
//  - WAKE: idle ignored. wake_cnt==WAKE_CYC-1 -> RUN, else wake_cnt++. Wake latency: act_valid first seen
//    in OFF at cycle t -> clk_en=1 at t+1 -> act_ready=1 at t+1+WAKE_CYC.
//  - idle_cnt saturates at all-ones (never wraps); thresh=all-ones still gates.
//  - Reset mid-OFF or mid-WAKE: next edge gives RUN, clk_en=1, act_ready=1; gate_events cleared.
//  - clk_en never toggles more than once per cycle. OFF is never entered with act_valid=1.
// STRUCTURE
//  - Package nv_clk_gate_pkg: state enum (RUN/HYST/OFF/WAKE, 2-bit, encodings above), default CNT_W/WAKE_CYC/EVT_W.
//  - One sub-module: nv_sat_counter #(W) (inc, clr -> cnt, saturating), used for idle_cnt and gate_events.
//  - The gate cell itself is instanced by the parent, not here; this block contains no clock logic.
// TESTING
//  1 thresh=3, all inputs low from cycle 0 -> HYST at 1, clk_en=0 and gated=1 from cycle 5, gate_events=1.
//  2 In OFF, act_valid=1 at t -> clk_en=1 at t+1, act_ready=1 at t+3 (WAKE_CYC=2), transfer at t+3,
//    no transfer before t+3.
//  3 thresh=3, act_valid pulses 1 on the cycle idle_cnt==3 -> state RUN, clk_en stays 1, gate_events unchanged.
//  4 cfg_force_on=1 with idle traffic for 1000 cycles -> clk_en stays 1. Raise it while OFF -> WAKE, then RUN.
//  5 reset asserted for 1 cycle while OFF -> next edge clk_en=1, act_ready=1, gate_events=0.
//    Also EVT_W=4, 20 gate cycles -> gate_events=15.
//  Assertions: clk_en never X after reset; act_valid held until accepted; no act_ready while clk_en=0.

Source files
------------

// File: rtl/nv_clk_gate_pkg.sv
// Shared types and default parameters for the idle-detect clock-gate controller.
package nv_clk_gate_pkg;

    localparam int unsigned CNT_W_DEF    = 8;
    localparam int unsigned WAKE_CYC_DEF = 2;
    localparam int unsigned EVT_W_DEF    = 16;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HYST = 2'd1,
        ST_OFF  = 2'd2,
        ST_WAKE = 2'd3
    } gate_state_e;

endpackage

// File: rtl/nv_sat_counter.sv
// Up-counter that clears on reset or clr and holds at all-ones instead of wrapping.
module nv_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/nv_clk_gate_ctrl.sv
// Idle-detect controller driving clk_en of the domain clock gate; gates after an idle
// hysteresis and holds act_ready low until the woken domain has settled.
module nv_clk_gate_ctrl
    import nv_clk_gate_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned WAKE_CYC = WAKE_CYC_DEF,
    parameter int unsigned EVT_W    = EVT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_force_on,
    input  logic [CNT_W-1:0] cfg_idle_thresh,
    input  logic             act_valid,
    output logic             act_ready,
    input  logic             dom_busy,
    output logic             clk_en,
    output logic             gated,
    output logic [EVT_W-1:0] gate_events
);

    localparam int unsigned          WAKE_W    = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
    localparam logic [WAKE_W-1:0]    WAKE_LAST = WAKE_W'(WAKE_CYC - 1);

    gate_state_e       state_q;
    gate_state_e       state_nxt;
    logic [WAKE_W-1:0] wake_cnt;
    logic [WAKE_W-1:0] wake_cnt_nxt;
    logic [CNT_W-1:0]  idle_cnt;
    logic              clk_en_nxt;
    logic              gated_nxt;
    logic              act_ready_nxt;
    logic              idle_c;
    logic              idle_inc_c;
    logic              idle_clr_c;
    logic              evt_inc_c;

    assign idle_c = !act_valid && !dom_busy && !cfg_force_on;

    // Idle hysteresis counter, restarted every cycle spent in RUN
    nv_sat_counter #(.W(CNT_W)) u_idle_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (idle_inc_c),
        .clr   (idle_clr_c),
        .cnt   (idle_cnt)
    );

    nv_sat_counter #(.W(EVT_W)) u_evt_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (evt_inc_c),
        .clr   (1'b0),
        .cnt   (gate_events)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            clk_en    <= 1'b1;
            gated     <= 1'b0;
            act_ready <= 1'b1;
            wake_cnt  <= '0;
        end else begin
            state_q   <= state_nxt;
            clk_en    <= clk_en_nxt;
            gated     <= gated_nxt;
            act_ready <= act_ready_nxt;
            wake_cnt  <= wake_cnt_nxt;
        end
    end

    // Non-idle always wins in HYST, so OFF is never entered with a pending request
    always_comb begin
        state_nxt    = state_q;
        clk_en_nxt   = clk_en;
        gated_nxt    = gated;
        wake_cnt_nxt = wake_cnt;
        idle_inc_c   = 1'b0;
        idle_clr_c   = 1'b0;
        evt_inc_c    = 1'b0;
        case (state_q)
            ST_RUN: begin
                idle_clr_c = 1'b1;
                if (idle_c) begin
                    state_nxt = ST_HYST;
                end
            end
            ST_HYST: begin
                if (!idle_c) begin
                    state_nxt = ST_RUN;
                end else if (idle_cnt >= cfg_idle_thresh) begin
                    state_nxt  = ST_OFF;
                    clk_en_nxt = 1'b0;
                    gated_nxt  = 1'b1;
                    evt_inc_c  = 1'b1;
                end else begin
                    idle_inc_c = 1'b1;
                end
            end
            ST_OFF: begin
                if (!idle_c) begin
                    state_nxt    = ST_WAKE;
                    clk_en_nxt   = 1'b1;
                    gated_nxt    = 1'b0;
                    wake_cnt_nxt = '0;
                end
            end
            ST_WAKE: begin
                if (wake_cnt == WAKE_LAST) begin
                    state_nxt = ST_RUN;
                end else begin
                    wake_cnt_nxt = wake_cnt + WAKE_W'(1);
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
        act_ready_nxt = (state_nxt == ST_RUN) || (state_nxt == ST_HYST);
    end

endmodule
